mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_byte_write_fifo.sv | 53 +++++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, loader regions and the write-FIFO entry.
package types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RD_VID = 2'd2,
    RD_CPU = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    IMAGE = 2'd0,
    MASK  = 2'd1,
    ROM   = 2'd2
  } region_t;

  typedef struct packed {
    region_t     region;
    logic [25:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

endpackage

// File: rtl/mem_arbiter_byte_write_fifo.sv
// Synchronous show-ahead FIFO for loader bytes; a push on a full FIFO succeeds only
// when a pop happens in the same cycle.
module byte_write_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader byte writes (via FIFO) beat video reads beat CPU reads.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate video/CPU read priority.
//
// state  | meaning
// IDLE   | no transaction; pick next requester
// WRITE  | FIFO head write outstanding
// RD_VID | video read outstanding
// RD_CPU | CPU read outstanding
module mem_arbiter
  import types::*;
#(
  parameter logic [25:0] IMAGE_BASE = 26'h0000000,
  parameter logic [25:0] MASK_BASE  = 26'h0300000,
  parameter logic [25:0] ROM_BASE   = 26'h0320000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_8bit,
  input  logic [25:0] addr_8bit,
  input  logic [7:0]  data_8bit,
  input  logic        image_download,
  input  logic        mask_config_download,
  input  logic        rom_download,
  input  logic        vid_rd_req,
  input  logic [25:0] vid_rd_addr,
  output logic        vid_rd_ack,
  output logic [7:0]  vid_rd_data,
  input  logic        cpu_rd_req,
  input  logic [25:0] cpu_rd_addr,
  output logic        cpu_rd_ack,
  output logic [7:0]  cpu_rd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [25:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        write_pending,
  output logic        overflow
);

  arb_state_t  state_q, state_d;
  wr_entry_t   fifo_din, fifo_dout;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [25:0] head_base;
  logic        vid_ok, cpu_ok, grant_vid, grant_cpu;
  logic        mem_req_d, mem_we_d, vid_ack_d, cpu_ack_d;
  logic [25:0] mem_addr_d;
  logic [7:0]  mem_wdata_d, vid_data_d, cpu_data_d;

  // Header bytes arrive with no region select and are simply not queued.
  assign fifo_push = wr_8bit && $onehot({rom_download, mask_config_download, image_download});

  always_comb begin
    fifo_din.region = IMAGE;
    if (mask_config_download) fifo_din.region = MASK;
    if (rom_download)         fifo_din.region = ROM;
    fifo_din.addr = addr_8bit;
    fifo_din.data = data_8bit;
  end

  byte_write_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    case (fifo_dout.region)
      MASK:    head_base = MASK_BASE;
      ROM:     head_base = ROM_BASE;
      default: head_base = IMAGE_BASE;
    endcase
  end

  // A requester still holding rd_req during its ack cycle must not be re-granted.
  assign vid_ok = vid_rd_req && !vid_rd_ack;
  assign cpu_ok = cpu_rd_req && !cpu_rd_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_vid;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vid <= 1'b0;
    end else if (state_q == IDLE && state_d == RD_VID) begin
      last_vid <= 1'b1;
    end else if (state_q == IDLE && state_d == RD_CPU) begin
      last_vid <= 1'b0;
    end
  end

  assign grant_vid = vid_ok && (!cpu_ok || !last_vid);
`else
  assign grant_vid = vid_ok;
`endif
  assign grant_cpu = cpu_ok && !grant_vid;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_data_d  = vid_rd_data;
    cpu_data_d  = cpu_rd_data;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_base + fifo_dout.addr;
          mem_wdata_d = fifo_dout.data;
        end else if (grant_vid) begin
          state_d    = RD_VID;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = vid_rd_addr;
        end else if (grant_cpu) begin
          state_d    = RD_CPU;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_rd_addr;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          fifo_pop  = 1'b1;
        end
      end
      RD_VID: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          vid_ack_d  = 1'b1;
          vid_data_d = mem_rdata;
        end
      end
      RD_CPU: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          cpu_ack_d  = 1'b1;
          cpu_data_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      vid_rd_ack  <= 1'b0;
      cpu_rd_ack  <= 1'b0;
      vid_rd_data <= '0;
      cpu_rd_data <= '0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      vid_rd_ack  <= vid_ack_d;
      cpu_rd_ack  <= cpu_ack_d;
      vid_rd_data <= vid_data_d;
      cpu_rd_data <= cpu_data_d;
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  assign busy          = (state_q != IDLE);
  assign write_pending = !fifo_empty;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_8bit;
  logic [25:0] addr_8bit;
  logic [7:0]  data_8bit;
  logic        image_download, mask_config_download, rom_download;
  logic        vid_rd_req;
  logic [25:0] vid_rd_addr;
  logic        vid_rd_ack;
  logic [7:0]  vid_rd_data;
  logic        cpu_rd_req;
  logic [25:0] cpu_rd_addr;
  logic        cpu_rd_ack;
  logic [7:0]  cpu_rd_data;
  logic        mem_req, mem_we;
  logic [25:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy, write_pending, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .wr_8bit              (wr_8bit),
    .addr_8bit            (addr_8bit),
    .data_8bit            (data_8bit),
    .image_download       (image_download),
    .mask_config_download (mask_config_download),
    .rom_download         (rom_download),
    .vid_rd_req           (vid_rd_req),
    .vid_rd_addr          (vid_rd_addr),
    .vid_rd_ack           (vid_rd_ack),
    .vid_rd_data          (vid_rd_data),
    .cpu_rd_req           (cpu_rd_req),
    .cpu_rd_addr          (cpu_rd_addr),
    .cpu_rd_ack           (cpu_rd_ack),
    .cpu_rd_data          (cpu_rd_data),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .busy                 (busy),
    .write_pending        (write_pending),
    .overflow             (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    wr_8bit = 0; addr_8bit = '0; data_8bit = '0;
    image_download = 0; mask_config_download = 0; rom_download = 0;
    vid_rd_req = 0; vid_rd_addr = '0; cpu_rd_req = 0; cpu_rd_addr = '0;
    mem_ack = 0; mem_rdata = '0;
    reset = 1;
    tick;
    tick;
    reset = 0;
  endtask

  // sel = {rom, mask, image}
  task automatic push_byte(input logic [2:0] sel, input logic [25:0] a, input logic [7:0] d);
    {rom_download, mask_config_download, image_download} = sel;
    addr_8bit = a; data_8bit = d; wr_8bit = 1;
    tick;
    wr_8bit = 0;
    {rom_download, mask_config_download, image_download} = 3'b000;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick;
      n++;
    end
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_req_timeout: mem_req=%b required 1", tag, mem_req);
    end
  endtask

  task automatic ack_once(input logic [7:0] rd);
    mem_rdata = rd;
    mem_ack = 1;
    tick;
    mem_ack = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({busy, write_pending, overflow, mem_req, mem_we, vid_rd_ack, cpu_rd_ack} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0000000",
               {busy, write_pending, overflow, mem_req, mem_we, vid_rd_ack, cpu_rd_ack});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, vid_rd_data, cpu_rd_data} !== 50'h0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h wdata=%h vid=%h cpu=%h required all 0",
               mem_addr, mem_wdata, vid_rd_data, cpu_rd_data);
    end
  endtask

  task automatic test_image_write;
    bit ok;
    do_reset;
    push_byte(3'b001, 26'h10, 8'hA5);
    n_cmp++;
    if ({write_pending, mem_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL img_after_push: pending/req=%b required 10", {write_pending, mem_req});
    end
    wait_req("img");
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 26'h0000010, 8'hA5, 1'b1}) begin
      n_bad++;
      $display("FAIL img_write: we=%b addr=%h wdata=%h busy=%b required 1 0000010 a5 1",
               mem_we, mem_addr, mem_wdata, busy);
    end
    ok = 1;
    repeat (3) begin
      tick;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 26'h10 || mem_wdata !== 8'hA5) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL img_hold: req=%b addr=%h wdata=%h required stable 1 0000010 a5",
               mem_req, mem_addr, mem_wdata);
    end
    ack_once(8'h00);
    n_cmp++;
    if ({mem_req, write_pending, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL img_done: req/pending/busy=%b required 000", {mem_req, write_pending, busy});
    end
    ok = 1;
    repeat (4) begin
      tick;
      if (mem_req !== 1'b0) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL img_single: extra mem_req seen, required none");
    end
  endtask

  task automatic test_regions;
    bit ok;
    do_reset;
    push_byte(3'b100, 26'h3, 8'h11);
    wait_req("rom");
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {26'h0320003, 8'h11}) begin
      n_bad++;
      $display("FAIL rom_addr: addr=%h wdata=%h required 0320003 11", mem_addr, mem_wdata);
    end
    ack_once(8'h00);
    push_byte(3'b010, 26'h5, 8'h22);
    wait_req("mask");
    n_cmp++;
    if ({mem_addr, mem_wdata} !== {26'h0300005, 8'h22}) begin
      n_bad++;
      $display("FAIL mask_addr: addr=%h wdata=%h required 0300005 22", mem_addr, mem_wdata);
    end
    ack_once(8'h00);
    push_byte(3'b100, 26'h3FFFFFF, 8'h33);
    wait_req("wrap");
    n_cmp++;
    if (mem_addr !== 26'h031FFFF) begin
      n_bad++;
      $display("FAIL rom_wrap: addr=%h required 031ffff", mem_addr);
    end
    ack_once(8'h00);
    tick;
    push_byte(3'b000, 26'h7, 8'h44);
    push_byte(3'b101, 26'h8, 8'h55);
    ok = (write_pending === 1'b0);
    repeat (4) begin
      tick;
      if (mem_req !== 1'b0 || write_pending !== 1'b0) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL no_select: req=%b pending=%b required 0 0", mem_req, write_pending);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [7:0] exp;
    do_reset;
    image_download = 1;
    wr_8bit = 1;
    for (int i = 0; i < 5; i++) begin
      addr_8bit = 26'(i);
      data_8bit = 8'(8'h50 + i);
      tick;
      if (i == 3) begin
        n_cmp++;
        if (overflow !== 1'b0) begin
          n_bad++;
          $display("FAIL ovf_at_four: overflow=%b required 0", overflow);
        end
      end
    end
    wr_8bit = 0;
    image_download = 0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: overflow=%b required 1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      wait_req("ovf_drain");
      exp = 8'(8'h50 + i);
      n_cmp++;
      if ({mem_addr, mem_wdata} !== {26'(i), exp}) begin
        n_bad++;
        $display("FAIL ovf_entry%0d: addr=%h wdata=%h required %h %h", i, mem_addr, mem_wdata, i, exp);
      end
      ack_once(8'h00);
    end
    ok = 1;
    repeat (4) begin
      tick;
      if (mem_req !== 1'b0 || write_pending !== 1'b0 || overflow !== 1'b1) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ovf_after_drain: req=%b pending=%b overflow=%b required 0 0 1",
               mem_req, write_pending, overflow);
    end
    do_reset;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_cleared: overflow=%b required 0", overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp;
    do_reset;
    image_download = 1;
    wr_8bit = 1;
    for (int i = 0; i < 4; i++) begin
      addr_8bit = 26'(i);
      data_8bit = 8'(8'h60 + i);
      tick;
    end
    addr_8bit = 26'h4;
    data_8bit = 8'h64;
    mem_ack = 1;
    tick;
    mem_ack = 0;
    wr_8bit = 0;
    image_download = 0;
    n_cmp++;
    if ({overflow, write_pending} !== 2'b01) begin
      n_bad++;
      $display("FAIL full_pushpop: overflow/pending=%b required 01", {overflow, write_pending});
    end
    for (int i = 1; i < 5; i++) begin
      wait_req("pp_drain");
      exp = 8'(8'h60 + i);
      n_cmp++;
      if (mem_wdata !== exp) begin
        n_bad++;
        $display("FAIL pp_entry%0d: wdata=%h required %h", i, mem_wdata, exp);
      end
      ack_once(8'h00);
    end
    n_cmp++;
    if (write_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL pp_empty: pending=%b required 0", write_pending);
    end
  endtask

  task automatic test_read_priority;
    do_reset;
    vid_rd_req = 1; vid_rd_addr = 26'h100;
    cpu_rd_req = 1; cpu_rd_addr = 26'h200;
    wait_req("rd_vid");
    n_cmp++;
    if ({mem_we, mem_addr} !== {1'b0, 26'h100}) begin
      n_bad++;
      $display("FAIL rd_first: we=%b addr=%h required 0 0000100", mem_we, mem_addr);
    end
    ack_once(8'h3C);
    n_cmp++;
    if ({vid_rd_ack, cpu_rd_ack, vid_rd_data} !== {2'b10, 8'h3C}) begin
      n_bad++;
      $display("FAIL vid_ack: vack=%b cack=%b vdata=%h required 1 0 3c", vid_rd_ack, cpu_rd_ack, vid_rd_data);
    end
    tick;
    n_cmp++;
    if ({vid_rd_ack, mem_req, mem_addr} !== {2'b01, 26'h200}) begin
      n_bad++;
      $display("FAIL rd_second: vack=%b req=%b addr=%h required 0 1 0000200", vid_rd_ack, mem_req, mem_addr);
    end
    vid_rd_req = 0;
    ack_once(8'hC3);
    n_cmp++;
    if ({cpu_rd_ack, vid_rd_ack, cpu_rd_data, vid_rd_data} !== {2'b10, 8'hC3, 8'h3C}) begin
      n_bad++;
      $display("FAIL cpu_ack: cack=%b vack=%b cdata=%h vdata=%h required 1 0 c3 3c",
               cpu_rd_ack, vid_rd_ack, cpu_rd_data, vid_rd_data);
    end
    cpu_rd_req = 0;
    tick;
    n_cmp++;
    if ({cpu_rd_ack, mem_req, cpu_rd_data} !== {2'b00, 8'hC3}) begin
      n_bad++;
      $display("FAIL cpu_ack_pulse: cack=%b req=%b cdata=%h required 0 0 c3", cpu_rd_ack, mem_req, cpu_rd_data);
    end
  endtask

  task automatic test_write_before_read;
    do_reset;
    push_byte(3'b001, 26'h20, 8'h5A);
    vid_rd_req = 1; vid_rd_addr = 26'h300;
    wait_req("wbr_w");
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 26'h20, 8'h5A}) begin
      n_bad++;
      $display("FAIL wbr_write: we=%b addr=%h wdata=%h required 1 0000020 5a", mem_we, mem_addr, mem_wdata);
    end
    ack_once(8'h00);
    wait_req("wbr_r");
    n_cmp++;
    if ({mem_we, mem_addr} !== {1'b0, 26'h300}) begin
      n_bad++;
      $display("FAIL wbr_read: we=%b addr=%h required 0 0000300", mem_we, mem_addr);
    end
    ack_once(8'h77);
    n_cmp++;
    if ({vid_rd_ack, vid_rd_data} !== {1'b1, 8'h77}) begin
      n_bad++;
      $display("FAIL wbr_ack: vack=%b vdata=%h required 1 77", vid_rd_ack, vid_rd_data);
    end
    vid_rd_req = 0;
  endtask

  task automatic test_read_drop;
    do_reset;
    cpu_rd_req = 1; cpu_rd_addr = 26'h400;
    tick;
    cpu_rd_req = 0;
    tick;
    tick;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 26'h400}) begin
      n_bad++;
      $display("FAIL drop_hold: req=%b addr=%h required 1 0000400", mem_req, mem_addr);
    end
    ack_once(8'h99);
    n_cmp++;
    if ({cpu_rd_ack, cpu_rd_data} !== {1'b1, 8'h99}) begin
      n_bad++;
      $display("FAIL drop_ack: cack=%b cdata=%h required 1 99", cpu_rd_ack, cpu_rd_data);
    end
  endtask

  task automatic test_reset_mid_write;
    bit ok;
    do_reset;
    push_byte(3'b001, 26'h30, 8'hEE);
    wait_req("rst_mid");
    reset = 1;
    tick;
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_req: mem_req=%b required 0", mem_req);
    end
    reset = 0;
    tick;
    mem_ack = 1;
    tick;
    mem_ack = 0;
    ok = 1;
    repeat (4) begin
      if ({mem_req, write_pending, busy, vid_rd_ack, cpu_rd_ack} !== 5'b0) ok = 0;
      tick;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rst_late_ack: req/pending/busy/vack/cack=%b required 00000",
               {mem_req, write_pending, busy, vid_rd_ack, cpu_rd_ack});
    end
  endtask

  initial begin
    test_reset;
    test_image_write;
    test_regions;
    test_overflow;
    test_full_push_pop;
    test_read_priority;
    test_write_before_read;
    test_read_drop;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
